// File: rtl/doorbell_chime.sv
// doorbell_chime: delayed sound selector with a self-timed chime sequence.
// Optional DOORBELL_CHIME_RETRIGGER_EN: press during a chime restarts it.
module doorbell_chime #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int DELAY    = 5,
  parameter int TONE_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   sounds,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic                        mode,
  input  logic                        press,
  output logic [WIDTH-1:0]            out,
  output logic                        busy
);
  localparam int IW = $clog2(CHANNELS);
  localparam int CW = (TONE_LEN > 1) ? $clog2(TONE_LEN) : 1;
  localparam logic [IW-1:0] LAST_CH  = IW'(CHANNELS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TONE_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_CHIME
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dly [DELAY];

  logic [WIDTH-1:0] w_snd [CHANNELS];
  logic [IW-1:0]    w_ch;
  logic [WIDTH-1:0] w_m;
  logic             w_tone_end;
  logic             w_last_ch;
  logic             w_restart;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_snd
    assign w_snd[k] = sounds[k*WIDTH +: WIDTH];
  end

  // Out-of-range manual selects clamp to the highest channel
  always_comb begin
    w_ch = sel;
    if (r_state == S_CHIME)
      w_ch = r_idx;
    else if (sel > LAST_CH)
      w_ch = LAST_CH;
  end

  always_comb begin
    w_m = '0;
    if (r_state == S_CHIME || !mode)
      w_m = w_snd[w_ch];
  end

  assign w_tone_end = (r_cnt == LAST_CNT);
  assign w_last_ch  = (r_idx == LAST_CH);

`ifdef DOORBELL_CHIME_RETRIGGER_EN
  assign w_restart = press;
`else
  assign w_restart = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mode && press) begin
            r_state <= S_CHIME;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CHIME: begin
          if (w_restart) begin
            r_idx <= '0;
            r_cnt <= '0;
          end else if (!w_tone_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_last_ch) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++)
        r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_m;
      for (int i = 1; i < DELAY; i++)
        r_dly[i] <= r_dly[i-1];
    end
  end

  assign out  = r_dly[DELAY-1];
  assign busy = (r_state == S_CHIME);

endmodule
